alu_scheduler: RTL and testbench

Two-requester scheduler that shares the single combinational 16-bit ALU between the CPU core (requester 0) and the coprocessor (requester 1). Round-robin arbitration, registered operand/opcode issue, multi-cycle hold for MUL/FMUL, registered results, per-requester flag registers. Sits between the requesters and an externally instantiated ALU.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/alu_scheduler.sv | 150 +++++++++++++++
 tb/tb_alu_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and flag definitions for the ALU scheduler
package alu_pkg;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] CMP  = 4'd2;
  localparam logic [3:0] CMPR = 4'd3;
  localparam logic [3:0] AND  = 4'd4;
  localparam logic [3:0] OR   = 4'd5;
  localparam logic [3:0] XOR  = 4'd6;
  localparam logic [3:0] NOT  = 4'd7;
  localparam logic [3:0] LSH  = 4'd8;
  localparam logic [3:0] RSH  = 4'd9;
  localparam logic [3:0] ARSH = 4'd10;
  localparam logic [3:0] MUL  = 4'd11;
  localparam logic [3:0] FMUL = 4'd12;

  // Opcodes from here upward have no ALU function and are reported via bad_op.
  localparam logic [3:0] FIRST_BAD_OP = 4'd13;

  localparam int FLAG_LOW  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MUL) || (op == FMUL);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, combinational grant, registered history
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins the first tie.
  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (|gnt) last_grant_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - shares one external 16-bit ALU between two requesters
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        busy,
  output logic [15:0] res_c,
  output logic [15:0] res_d,
  output logic        bad_op,
  output logic [2:0]  flags0,
  output logic [2:0]  flags1,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [15:0] alu_c,
  input  logic [15:0] alu_d,
  input  logic        alu_low,
  input  logic        alu_negative,
  input  logic        alu_zero
);

  localparam logic [2:0] LONG_CNT = 3'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_opcode_q, alu_opcode_d;
  logic [15:0] res_c_q, res_c_d;
  logic [15:0] res_d_q, res_d_d;
  logic [2:0]  flags0_q, flags0_d;
  logic [2:0]  flags1_q, flags1_d;
  logic [1:0]  done_q, done_d;
  logic        bad_op_q, bad_op_d;

  logic [3:0]  sel_op;
  logic [2:0]  alu_flags;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (state_q == IDLE),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    alu_flags            = 3'b000;
    alu_flags[FLAG_LOW]  = alu_low;
    alu_flags[FLAG_NEG]  = alu_negative;
    alu_flags[FLAG_ZERO] = alu_zero;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    res_c_d      = res_c_q;
    res_d_d      = res_d_q;
    flags0_d     = flags0_q;
    flags1_d     = flags1_q;
    done_d       = 2'b00;
    bad_op_d     = 1'b0;
    sel_op       = gnt[1] ? op1 : op0;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d      = gnt[1];
          alu_opcode_d = sel_op;
          alu_a_d      = gnt[1] ? a1 : a0;
          alu_b_d      = gnt[1] ? b1 : b0;
          cnt_d        = is_long_op(sel_op) ? LONG_CNT : 3'd0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          res_c_d = alu_c;
          res_d_d = alu_d;
          if (owner_q) flags1_d = alu_flags;
          else         flags0_d = alu_flags;
          done_d[owner_q] = 1'b1;
          bad_op_d        = (alu_opcode_q >= FIRST_BAD_OP);
          state_d         = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      owner_q      <= 1'b0;
      alu_a_q      <= 16'h0000;
      alu_b_q      <= 16'h0000;
      alu_opcode_q <= 4'h0;
      res_c_q      <= 16'h0000;
      res_d_q      <= 16'h0000;
      flags0_q     <= 3'b000;
      flags1_q     <= 3'b000;
      done_q       <= 2'b00;
      bad_op_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      res_c_q      <= res_c_d;
      res_d_q      <= res_d_d;
      flags0_q     <= flags0_d;
      flags1_q     <= flags1_d;
      done_q       <= done_d;
      bad_op_q     <= bad_op_d;
    end
  end

  assign busy       = (state_q == EXEC);
  assign done       = done_q;
  assign bad_op     = bad_op_q;
  assign res_c      = res_c_q;
  assign res_d      = res_d_q;
  assign flags0     = flags0_q;
  assign flags1     = flags1_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - scoreboard bench for alu_scheduler with a behavioural ALU
module tb_alu_scheduler;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic [1:0]  gnt, done;
  logic        busy, bad_op;
  logic [15:0] res_c, res_d, alu_a, alu_b, alu_c, alu_d;
  logic [2:0]  flags0, flags1;
  logic [3:0]  alu_opcode;
  logic        alu_low, alu_negative, alu_zero;

  always #5 clk = ~clk;

  alu_scheduler #(.MUL_CYCLES(2)) dut (
    .clk(clk), .reset_n(rst_n), .req(req),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .busy(busy), .res_c(res_c), .res_d(res_d),
    .bad_op(bad_op), .flags0(flags0), .flags1(flags1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_d(alu_d),
    .alu_low(alu_low), .alu_negative(alu_negative), .alu_zero(alu_zero)
  );

  // Behavioural ALU: low = carry/borrow for add/sub/compare, MUL gives C=high word, D=low word.
  logic [16:0] tmp17;
  logic [31:0] prod;
  always_comb begin
    alu_c = 16'h0000; alu_d = 16'h0000; alu_low = 1'b0; tmp17 = 17'h0; prod = 32'h0;
    case (alu_opcode)
      ADD:       begin tmp17 = {1'b0, alu_a} + {1'b0, alu_b}; alu_c = tmp17[15:0]; alu_low = tmp17[16]; end
      SUB, CMP:  begin tmp17 = {1'b0, alu_a} - {1'b0, alu_b}; alu_c = tmp17[15:0]; alu_low = tmp17[16]; end
      CMPR:      begin tmp17 = {1'b0, alu_b} - {1'b0, alu_a}; alu_c = tmp17[15:0]; alu_low = tmp17[16]; end
      AND:       alu_c = alu_a & alu_b;
      OR:        alu_c = alu_a | alu_b;
      XOR:       alu_c = alu_a ^ alu_b;
      NOT:       alu_c = ~alu_a;
      LSH:       alu_c = alu_a << alu_b[3:0];
      RSH:       alu_c = alu_a >> alu_b[3:0];
      ARSH:      alu_c = $unsigned($signed(alu_a) >>> alu_b[3:0]);
      MUL, FMUL: begin prod = alu_a * alu_b; alu_c = prod[31:16]; alu_d = prod[15:0]; end
      default:   ;
    endcase
    alu_zero     = (alu_c == 16'h0000);
    alu_negative = alu_c[15];
  end

  typedef struct {
    logic [1:0]  done;
    logic [15:0] c;
    logic [15:0] d;
    logic [2:0]  f0;
    logic [2:0]  f1;
    logic        bad;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [2:0] exp_f0 = 3'b000;
  logic [2:0] exp_f1 = 3'b000;
  int   t, tp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_done(input logic own, input logic [15:0] c, input logic [15:0] d,
                             input logic [2:0] f, input logic bad, input int due);
    if (own) exp_f1 = f;
    else     exp_f0 = f;
    sb.push_back('{done: (own ? 2'b10 : 2'b01), c: c, d: d, f0: exp_f0, f1: exp_f1, bad: bad, cyc: due});
  endtask

  task automatic set0(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    op0 = op; a0 = a; b0 = b;
  endtask

  task automatic set1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    op1 = op; a1 = a; b1 = b;
  endtask

  task automatic wait_gnt(input logic [1:0] exp, input string name, output int tg);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) break;
    end
    tg = cyc;
    check(name, 32'(gnt), 32'(exp));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) break;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00;
    exp_f0 = 3'b000; exp_f1 = 3'b000;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done != 2'b00) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'h0);
          end else begin
            mon_e = sb.pop_front();
            check("done_vec",   32'(done),   32'(mon_e.done));
            check("done_cycle", cyc,         mon_e.cyc);
            check("res_c",      32'(res_c),  32'(mon_e.c));
            check("res_d",      32'(res_d),  32'(mon_e.d));
            check("flags0",     32'(flags0), 32'(mon_e.f0));
            check("flags1",     32'(flags1), 32'(mon_e.f1));
            check("bad_op",     32'(bad_op), 32'(mon_e.bad));
          end
        end else begin
          check("bad_op_idle", 32'(bad_op), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 2'b00;
    set0(ADD, 16'h0, 16'h0); set1(ADD, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);      check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);    check("rst_bad_op", 32'(bad_op), 0);
    check("rst_res_c", 32'(res_c), 0);  check("rst_res_d", 32'(res_d), 0);
    check("rst_alu_a", 32'(alu_a), 0);  check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_opcode), 0);
    check("rst_flags0", 32'(flags0), 0); check("rst_flags1", 32'(flags1), 0);
    rst_n = 1'b1;

    // Single ADD from requester 0; operands scrambled after grant.
    @(posedge clk); #1;
    set0(ADD, 16'h0003, 16'h0004); req = 2'b01;
    wait_gnt(2'b01, "add_gnt", t);
    expect_done(1'b0, 16'h0007, 16'h0000, 3'b000, 1'b0, t + 2);
    @(posedge clk); #1;
    req = 2'b00; set0(SUB, 16'hFFFF, 16'hFFFF);
    check("add_alu_a_latched", 32'(alu_a), 32'h0003);
    check("add_busy", 32'(busy), 1);
    wait_drain("add_drain");

    // Both requesting continuously after reset: 01,10,01,10 back to back.
    do_reset();
    @(posedge clk); #1;
    set0(ADD, 16'h0001, 16'h0001); set1(ADD, 16'h0010, 16'h0020); req = 2'b11;
    tp = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt((k % 2) ? 2'b10 : 2'b01, "rr_gnt", t);
      if (k > 0) check("rr_spacing", t - tp, 2);
      tp = t;
      expect_done(1'(k % 2), (k % 2) ? 16'h0030 : 16'h0002, 16'h0000, 3'b000, 1'b0, t + 2);
      @(posedge clk); #1;
    end
    req = 2'b00;
    wait_drain("rr_drain");

    // MUL from requester 1 holds EXEC for two cycles.
    @(posedge clk); #1;
    set1(MUL, 16'h0100, 16'h0100); req = 2'b10;
    wait_gnt(2'b10, "mul_gnt", t);
    expect_done(1'b1, 16'h0001, 16'h0000, 3'b000, 1'b0, t + 3);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk); check("mul_busy1", 32'(busy), 1);
    @(negedge clk); check("mul_busy2", 32'(busy), 1);
    @(negedge clk); check("mul_busy_end", 32'(busy), 0);
    wait_drain("mul_drain");

    // CMP equal sets flags1.zero; later SUB on requester 0 leaves flags1 alone.
    @(posedge clk); #1;
    set1(CMP, 16'h0005, 16'h0005); req = 2'b10;
    wait_gnt(2'b10, "cmp_gnt", t);
    expect_done(1'b1, 16'h0000, 16'h0000, 3'b001, 1'b0, t + 2);
    @(posedge clk); #1; req = 2'b00;
    wait_drain("cmp_drain");
    @(posedge clk); #1;
    set0(SUB, 16'h0002, 16'h0007); req = 2'b01;
    wait_gnt(2'b01, "sub_gnt", t);
    expect_done(1'b0, 16'hFFFB, 16'h0000, 3'b110, 1'b0, t + 2);
    @(posedge clk); #1; req = 2'b00;
    wait_drain("sub_drain");

    // Invalid opcode 0xE: C=0 from the ALU default, bad_op pulses with done.
    @(posedge clk); #1;
    set0(4'hE, 16'h0005, 16'h0006); req = 2'b01;
    wait_gnt(2'b01, "bad_gnt", t);
    expect_done(1'b0, 16'h0000, 16'h0000, 3'b001, 1'b1, t + 2);
    @(posedge clk); #1; req = 2'b00;
    wait_drain("bad_drain");

    // Reset in the middle of a MUL aborts with no done.
    @(posedge clk); #1;
    set0(MUL, 16'h0007, 16'h0009); req = 2'b01;
    wait_gnt(2'b01, "abort_gnt", t);
    @(posedge clk); #1;
    req = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);     check("abort_done", 32'(done), 0);
    check("abort_alu_a", 32'(alu_a), 0);   check("abort_alu_op", 32'(alu_opcode), 0);
    check("abort_flags0", 32'(flags0), 0); check("abort_flags1", 32'(flags1), 0);
    exp_f0 = 3'b000; exp_f1 = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    set0(ADD, 16'h0003, 16'h0004); set1(ADD, 16'h0001, 16'h0001); req = 2'b11;
    wait_gnt(2'b01, "post_reset_gnt", t);
    expect_done(1'b0, 16'h0007, 16'h0000, 3'b000, 1'b0, t + 2);
    @(posedge clk); #1; req = 2'b00;
    wait_drain("post_reset_drain");

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
